// File: rtl/seq_stepper.sv
// Sequence player: steps through 128-bit BRAM words at a programmable cycles-per-step rate.
// Optional build macro SEQ_STEPPER_HOLD_LAST_EN keeps the final word on seq_data in DONE.
module seq_stepper #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           samples_per_step,
    input  logic [ADDR_WIDTH-1:0] last_step,
    input  logic [15:0]           num_repeats,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [127:0]          mem_rdata,
    output logic [127:0]          seq_data,
    output logic                  seq_active,
    output logic [ADDR_WIDTH-1:0] step_index,
    output logic [15:0]           repeat_count,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

    state_t                state_reg;
    logic [31:0]           spc_reg;
    logic [ADDR_WIDTH-1:0] last_reg;
    logic [15:0]           reps_reg;
    logic [31:0]           cnt_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [127:0]          seq_data_reg;
    logic [ADDR_WIDTH-1:0] step_index_reg;
    logic [15:0]           repeat_count_reg;
    logic                  done_reg;
    logic                  seq_active_reg;

    logic [31:0]           spc_clamped;
    logic                  start_ok;
    logic                  boundary;
    logic                  pass_end;
    logic                  finish;
    logic [15:0]           rc_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign spc_clamped = (samples_per_step < 32'd2) ? 32'd2 : samples_per_step;
    assign start_ok    = start && !stop;
    assign boundary    = (cnt_reg == spc_reg - 32'd1);
    assign pass_end    = boundary && (step_index_reg == last_reg);
    assign rc_next     = (repeat_count_reg == 16'hFFFF) ? 16'hFFFF : repeat_count_reg + 16'd1;
    assign finish      = pass_end && (reps_reg != 16'd0) && (rc_next == reps_reg);
    // Wrap on last_step rather than on the memory depth.
    assign addr_next   = (mem_addr_reg == last_reg) ? '0 : mem_addr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_reg        <= IDLE;
            spc_reg          <= 32'd2;
            last_reg         <= '0;
            reps_reg         <= '0;
            cnt_reg          <= '0;
            mem_addr_reg     <= '0;
            seq_data_reg     <= '0;
            step_index_reg   <= '0;
            repeat_count_reg <= '0;
            done_reg         <= 1'b0;
            seq_active_reg   <= 1'b0;
        end else if (stop && state_reg != IDLE) begin
            // step_index and repeat_count stay put so the CPU can read where it stopped.
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mem_addr_reg   <= '0;
            seq_data_reg   <= '0;
            done_reg       <= 1'b0;
            seq_active_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // Every accepted start begins a fresh pass count.
                    if (start_ok) begin
                        state_reg        <= PRIME;
                        spc_reg          <= spc_clamped;
                        last_reg         <= last_step;
                        reps_reg         <= num_repeats;
                        repeat_count_reg <= '0;
                        done_reg         <= 1'b0;
                    end
                end
                PRIME: begin
                    state_reg      <= RUN;
                    seq_active_reg <= 1'b1;
                    seq_data_reg   <= mem_rdata;
                    step_index_reg <= '0;
                    mem_addr_reg   <= (last_reg == '0) ? '0 : ADDR_WIDTH'(1);
                    cnt_reg        <= '0;
                end
                RUN: begin
                    if (boundary) begin
                        cnt_reg <= '0;
                        if (pass_end)
                            repeat_count_reg <= rc_next;
                        if (finish) begin
                            state_reg      <= DONE;
                            seq_active_reg <= 1'b0;
                            done_reg       <= 1'b1;
                            mem_addr_reg   <= '0;
`ifndef SEQ_STEPPER_HOLD_LAST_EN
                            seq_data_reg   <= '0;
`endif
                        end else begin
                            seq_data_reg   <= mem_rdata;
                            step_index_reg <= mem_addr_reg;
                            mem_addr_reg   <= addr_next;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_addr     = mem_addr_reg;
    assign seq_data     = seq_data_reg;
    assign seq_active   = seq_active_reg;
    assign step_index   = step_index_reg;
    assign repeat_count = repeat_count_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_seq_stepper.sv
// Directed vector bench for seq_stepper with a registered-read BRAM model (16 words).
module tb_seq_stepper;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [31:0]    samples_per_step = 32'd3;
    logic [AW-1:0]  last_step = '0;
    logic [15:0]    num_repeats = '0;
    logic [AW-1:0]  mem_addr;
    logic [127:0]   mem_rdata = '0;
    logic [127:0]   seq_data;
    logic           seq_active;
    logic [AW-1:0]  step_index;
    logic [15:0]    repeat_count;
    logic           done;

    int checks = 0;
    int errors = 0;
    int vnum = 0;

    logic [127:0] mem [16];

    seq_stepper #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .stop(stop),
        .samples_per_step(samples_per_step), .last_step(last_step),
        .num_repeats(num_repeats), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .seq_data(seq_data), .seq_active(seq_active), .step_index(step_index),
        .repeat_count(repeat_count), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    typedef struct {
        logic          rstn, st, sp;
        logic [31:0]   spc;
        logic [AW-1:0] last;
        logic [15:0]   reps;
        logic [127:0]  e_seq;
        logic [AW-1:0] e_step;
        logic [15:0]   e_rc;
        logic          e_done, e_act;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[$];
    logic [31:0]   c_spc;
    logic [AW-1:0] c_last;
    logic [15:0]   c_reps;

    function automatic logic [127:0] word(int k);
        return {32'hF00D_0000 + 32'(k), 32'h1234_5678 ^ 32'(k), 32'h0, 32'h0000_000A + 32'(k)};
    endfunction

    // Value seq_data holds in DONE when word k was the last one shown.
    function automatic logic [127:0] dseq(int k);
`ifdef SEQ_STEPPER_HOLD_LAST_EN
        return word(k);
`else
        return (k < 0) ? 128'h1 : 128'h0;
`endif
    endfunction

    function automatic vec_t mk(logic rstn, logic st, logic sp, logic [31:0] spc, logic [AW-1:0] last,
                                logic [15:0] reps, logic [127:0] es, logic [AW-1:0] est,
                                logic [15:0] erc, logic ed, logic ea, logic [AW-1:0] eaddr);
        vec_t v;
        v.rstn = rstn; v.st = st; v.sp = sp; v.spc = spc; v.last = last; v.reps = reps;
        v.e_seq = es; v.e_step = est; v.e_rc = erc; v.e_done = ed; v.e_act = ea; v.e_addr = eaddr;
        return v;
    endfunction

    task automatic add(logic rstn, logic st, logic sp, logic [127:0] es, logic [AW-1:0] est,
                       logic [15:0] erc, logic ed, logic ea, logic [AW-1:0] eaddr);
        tbl.push_back(mk(rstn, st, sp, c_spc, c_last, c_reps, es, est, erc, ed, ea, eaddr));
    endtask

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec %0d %s: got %h want %h", vnum, name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        aresetn = v.rstn; start = v.st; stop = v.sp;
        samples_per_step = v.spc; last_step = v.last; num_repeats = v.reps;
        @(posedge clk);
        #1;
        $display("vec %0d %s rst_n=%b start=%b stop=%b seq=%h step=%0d rc=%0d done=%b act=%b addr=%0d",
                 vnum, tag, v.rstn, v.st, v.sp, seq_data, step_index, repeat_count, done, seq_active, mem_addr);
        chk("seq_data", seq_data, v.e_seq);
        chk("step_index", 128'(step_index), 128'(v.e_step));
        chk("repeat_count", 128'(repeat_count), 128'(v.e_rc));
        chk("done", 128'(done), 128'(v.e_done));
        chk("seq_active", 128'(seq_active), 128'(v.e_act));
        chk("mem_addr", 128'(mem_addr), 128'(v.e_addr));
        vnum++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = word(i);

        // Reset, then spc=3 last=1 reps=1 with start at edge 0.
        c_spc = 32'd3; c_last = 4'd1; c_reps = 16'd1;
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 1);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 1);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 1);
        add(1, 0, 0, word(1), 1, 0, 0, 1, 0);
        c_spc = 32'd7; c_last = 4'd0;
        add(1, 0, 0, word(1), 1, 0, 0, 1, 0);
        c_spc = 32'd3; c_last = 4'd1;
        add(1, 0, 0, word(1), 1, 0, 0, 1, 0);
        add(1, 0, 0, dseq(1), 1, 1, 1, 0, 0);
        add(1, 0, 0, dseq(1), 1, 1, 1, 0, 0);
        add(1, 1, 0, dseq(1), 1, 0, 0, 0, 0);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        // start and stop together from IDLE: no PRIME, so no RUN on the following edge.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // spc=0 (clamped to 2), last=2, infinite; start during RUN is ignored; stop at step 1.
        c_spc = 32'd0; c_last = 4'd2; c_reps = 16'd0;
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 1);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 1);
        add(1, 0, 0, word(1), 1, 0, 0, 1, 2);
        add(1, 1, 0, word(1), 1, 0, 0, 1, 2);
        add(1, 0, 0, word(2), 2, 0, 0, 1, 0);
        add(1, 0, 0, word(2), 2, 0, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 1, 0, 1, 1);
        add(1, 0, 0, word(0), 0, 1, 0, 1, 1);
        add(1, 0, 0, word(1), 1, 1, 0, 1, 2);
        add(1, 0, 0, word(1), 1, 1, 0, 1, 2);
        add(1, 0, 0, word(2), 2, 1, 0, 1, 0);
        add(1, 0, 0, word(2), 2, 1, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 2, 0, 1, 1);
        add(1, 0, 0, word(0), 0, 2, 0, 1, 1);
        add(1, 0, 0, word(1), 1, 2, 0, 1, 2);
        add(1, 0, 1, 0, 1, 2, 0, 0, 0);
        add(1, 0, 0, 0, 1, 2, 0, 0, 0);
        // spc=1 (clamped to 2), last=0, three passes.
        c_spc = 32'd1; c_last = 4'd0; c_reps = 16'd3;
        add(1, 1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 0, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 1, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 1, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 2, 0, 1, 0);
        add(1, 0, 0, word(0), 0, 2, 0, 1, 0);
        add(1, 0, 0, dseq(0), 0, 3, 1, 0, 0);
        add(1, 0, 0, dseq(0), 0, 3, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "tbl");

        // Full-depth pass with last_step all ones: address wraps 15 -> 0.
        c_spc = 32'd2; c_last = 4'hF; c_reps = 16'd1;
        run_vec(mk(1, 1, 0, c_spc, c_last, c_reps, dseq(0), 0, 0, 0, 0, 0), "wrap");
        for (int k = 0; k < 16; k++)
            for (int r = 0; r < 2; r++)
                run_vec(mk(1, 0, 0, c_spc, c_last, c_reps, word(k), 4'(k), 0, 0, 1, 4'(k + 1)), "wrap");
        run_vec(mk(1, 0, 0, c_spc, c_last, c_reps, dseq(15), 4'hF, 1, 1, 0, 0), "wrap");

        // Reset mid-RUN (with start held high), then a replay from word 0.
        run_vec(mk(1, 1, 0, c_spc, c_last, c_reps, dseq(15), 4'hF, 0, 0, 0, 0), "rst");
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 2; r++)
                run_vec(mk(1, 0, 0, c_spc, c_last, c_reps, word(k), 4'(k), 0, 0, 1, 4'(k + 1)), "rst");
        run_vec(mk(0, 1, 0, c_spc, c_last, c_reps, 0, 0, 0, 0, 0, 0), "rst");
        run_vec(mk(1, 1, 0, c_spc, c_last, c_reps, 0, 0, 0, 0, 0, 0), "rst");
        run_vec(mk(1, 0, 0, c_spc, c_last, c_reps, word(0), 0, 0, 0, 1, 1), "rst");
        run_vec(mk(1, 0, 1, c_spc, c_last, c_reps, 0, 0, 0, 0, 0, 0), "rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_stepper.md
# seq_stepper

Sequence player that sits directly upstream of the sequence slice register. It steps through a BRAM of 128-bit sequence words at a programmable rate of clock cycles per step, and presents the current word on `seq_data`. The word layout is owned by the slice and is opaque here. It supports finite or infinite repetition, start/stop control and status readback for the CPU register block.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: sequence memory address width (depth 2^ADDR_WIDTH words).

Ports:
- `clk`  in  1: clock.
- `aresetn`  in  1: reset, synchronous, active-low.
- `start`  in  1: single-cycle start pulse.
- `stop`  in  1: single-cycle stop pulse.
- `samples_per_step`  in  32: clock cycles per step. Values 0 and 1 are treated as 2.
- `last_step`  in  ADDR_WIDTH: index of the final word in one pass.
- `num_repeats`  in  16: number of passes; 0 means infinite.
- `mem_addr`  out  ADDR_WIDTH: read address to the synchronous BRAM.
- `mem_rdata`  in  128: BRAM read data, valid one cycle after `mem_addr`.
- `seq_data`  out  128: current sequence word, to the slice stage.
- `seq_active`  out  1: high while in RUN.
- `step_index`  out  ADDR_WIDTH: index of the word currently on `seq_data`.
- `repeat_count`  out  16: number of completed passes.
- `done`  out  1: finite sequence has completed; sticky.

## Operation
- States: IDLE, PRIME, RUN, DONE.
- `samples_per_step` (after clamping), `last_step` and `num_repeats` are latched on the edge where `start` is accepted. Later changes are ignored until the next start.
- IDLE:
  - `mem_addr` = 0 and `seq_data` = 0.
  - `start` -> PRIME. PRIME exists so that memory writes made before start are visible in the first word.
- PRIME: unconditional -> RUN at the next edge. On that edge:
  - `seq_data` <= `mem_rdata` (word 0) and `step_index` <= 0.
  - `mem_addr` <= 1, or 0 if `last_step` = 0.
  - Cycle counter <= 0.
- RUN:
  - The cycle counter increments every cycle. The boundary edge is the edge where counter = spc−1.
  - On a boundary edge: `seq_data` <= `mem_rdata`, `step_index` <= `mem_addr`, counter <= 0, and `mem_addr` <= `mem_addr`+1, wrapping to 0 after `last_step`.
  - End of pass: a boundary edge where `step_index` = `last_step`. `repeat_count` increments, saturating at 0xFFFF.
  - If `num_repeats` ≠ 0 and the incremented count equals `num_repeats`: -> DONE. `seq_data` <= 0, `done` <= 1 and `mem_addr` <= 0; no new word is loaded.
- DONE:
  - Outputs are held.
  - `start` -> PRIME; this clears `done` and `repeat_count`.
- `stop` in PRIME, RUN or DONE -> IDLE at the next edge:
  - `seq_data` <= 0, `mem_addr` <= 0, `done` <= 0.
  - `repeat_count` and `step_index` are held for readback.
- Simultaneous events:
  - `start` and `stop` high together: stop wins.
  - `start` while in PRIME or RUN: ignored.
- Address wrap is modulo `last_step`+1, never modulo 2^ADDR_WIDTH. A `last_step` of all ones is legal.

## Timing
- Reset (`aresetn` low at an edge): state IDLE; `seq_data`, `mem_addr`, `step_index`, `repeat_count`, counter = 0; `seq_active`, `done` = 0. Reset has priority over all inputs, including mid-RUN.
- Latency:
  - Start accepted at edge S -> PRIME after S -> word 0 on `seq_data` after edge S+1.
  - Each word is held for exactly spc cycles.
- Memory timing: `mem_addr` is stable for at least spc−1 ≥ 1 cycles before it is consumed. This guarantees `mem_rdata` is valid at every boundary.
- `seq_active` is a registered state decode: high exactly while in RUN.
- `done` asserts on the same edge that `seq_data` goes to 0.

## Configuration
- `SEQ_STEPPER_HOLD_LAST_EN`:
  - Defined: on entry to DONE, `seq_data` keeps the last word of the final pass instead of clearing, so downstream values and flags persist. `stop` still clears to 0.
  - Undefined: DONE clears `seq_data` to 0, as described above.

## Test plan
- spc=3, last_step=1, num_repeats=1, memory w0=0xA, w1=0xB, start at edge 0 -> expected response:
  - `seq_data` = 0xA after edges 1–3 and 0xB after edges 4–6.
  - DONE at edge 7: `seq_data` = 0, `done` = 1, `repeat_count` = 1.
- spc=0, last_step=2, num_repeats=0 -> expected response:
  - Each word is held for 2 cycles; the pattern w0,w1,w2,w0… wraps indefinitely.
  - `repeat_count` increments every 6 cycles and `done` stays 0.
- `stop` pulse mid-RUN at step 1 -> expected response:
  - IDLE at the next edge, `seq_data` = 0, `mem_addr` = 0.
  - `step_index` = 1 is held.
- `start` and `stop` in the same cycle from IDLE -> expected response: the block stays in IDLE. Separately, `start` during RUN -> expected response: no change in sequence progress.
- `aresetn` low for 1 cycle mid-RUN -> expected response: all outputs are 0 after that edge; a later `start` replays from w0.
- With `SEQ_STEPPER_HOLD_LAST_EN` defined, repeat test 1 -> expected response: `seq_data` = 0xB persists in DONE; a subsequent `stop` -> 0.
